div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle signed integer divider; the responder end of the ALU's divide operation.
- ALU drives operands plus a start pulse; the unit returns a 64-bit {remainder, quotient} result with a done pulse.
- The ALU routes this result onto its 64-bit C output (remainder to HI half, quotient to LO half).
- Restoring division on operand magnitudes, one quotient bit per clock, then sign fix-up.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
clock  input  1  system clock, rising-edge active.
clear  input  1  asynchronous, active-low reset (reset while clear = 0).
start  input  1  request pulse, sampled on rising edge while in IDLE.
dividend  input  WIDTH  signed two's-complement dividend (ALU operand A).
divisor  input  WIDTH  signed two's-complement divisor (ALU operand B).
busy  output  1  high in CALC and FIX.
done  output  1  one-cycle pulse, result valid.
div_by_zero  output  1  sticky flag for the last operation; cleared on the next accepted start.
result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.

Behaviour:
- Reset (clear = 0, asynchronous):
  - state = IDLE; busy, done, div_by_zero = 0; result = 0.
  - All internal registers (including the iteration counter) = 0.
  - Applies at any point, including mid-CALC; the in-flight operation is discarded with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start = 1, divisor != 0:
  - Latch the magnitudes |dividend| and |divisor|.
  - Latch the sign flags: sq = sign(dividend) XOR sign(divisor); sr = sign(dividend).
  - Set the partial remainder (WIDTH+1 bits) to 0 and the counter to WIDTH-1.
  - Clear div_by_zero. Go to CALC.
- IDLE, start = 1, divisor == 0:
  - Go directly to DONE.
  - result = {dividend, all-ones}; div_by_zero = 1.
- CALC, each cycle:
  - Shift {remainder, quotient} left by 1, bringing in the next dividend MSB.
  - Trial-subtract |divisor|. If non-negative, keep the difference and set quotient LSB = 1; else restore and set LSB = 0.
  - Counter decrements. After WIDTH iterations (counter reaches 0), go to FIX.
- FIX (1 cycle):
  - Negate the quotient if sq = 1; negate the remainder if sr = 1.
  - Write result. Go to DONE.
- DONE (1 cycle): done = 1, then go to IDLE.
- Latency:
  - done is high in the cycle after rising edge WIDTH+2, counting the start-sampling edge as edge 0. This is 34 cycles for WIDTH = 32.
  - For divide-by-zero, done is high after edge 1.
- Rounding:
  - Quotient truncates toward zero.
  - Remainder carries the sign of the dividend; a zero remainder is +0.
  - Invariant: dividend = quotient*divisor + remainder.
- Overflow: -2^(WIDTH-1) / -1 yields quotient 0x80000000, remainder 0. div_by_zero is not set.
- Simultaneous events:
  - start in CALC, FIX or DONE is ignored, and the operands are not re-latched.
  - Operand changes after acceptance have no effect.
- result holds its value from FIX (or the divide-by-zero DONE) until the next FIX, the next divide-by-zero, or reset.
- busy is 0 in IDLE and DONE.

Test Plan:
1. dividend = 100, divisor = 7, start for 1 cycle -> done exactly 34 cycles later; result = 0x00000002_0000000E; div_by_zero = 0; busy high for 33 cycles.
2. Signed operands:
   - -100 / 7 -> result = 0xFFFFFFFE_FFFFFFF2.
   - 100 / -7 -> result = 0x00000002_FFFFFFF2.
   - -100 / -7 -> result = 0xFFFFFFFE_0000000E.
3. 7 / 0 -> done 1 cycle after start; div_by_zero = 1; result = 0x00000007_FFFFFFFF. A following 9 / 3 -> div_by_zero = 0, result = 0x00000000_00000003.
4. 0x80000000 / 0xFFFFFFFF -> result = 0x00000000_80000000, div_by_zero = 0. Also 5 / 9 -> result = 0x00000005_00000000.
5. Start 1000 / 10, change operands and pulse start again at cycle 5 -> second start ignored; single done at cycle 34; result = 0x00000000_00000064.
6. Start 50 / 5, assert clear = 0 at cycle 10 -> busy, done and result go to 0 immediately (asynchronously), with no done pulse. Release clear, start 50 / 5 -> result = 0x00000000_0000000A after 34 cycles.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed restoring divider returning {remainder, quotient}
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;

   // quo starts as |dividend| and is shifted out MSB-first while quotient bits shift in
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] rem;
   logic [CNT_W-1:0] cnt;
   logic             sq;
   logic             sr;

   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dvs_abs;
   logic             divisor_zero;
   logic [WIDTH:0]   trial_shift;
   logic [WIDTH:0]   trial_diff;

   // Operand magnitudes and the trial subtraction of one restoring step
   always_comb begin
      dvd_abs      = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_abs      = divisor[WIDTH-1]  ? -divisor  : divisor;
      divisor_zero = (divisor == '0);
      // The remainder is always below |divisor| <= 2^(WIDTH-1), so the shifted
      // value never sets bit WIDTH and trial_diff[WIDTH] is a clean borrow flag.
      trial_shift  = {rem, quo[WIDTH-1]};
      trial_diff   = trial_shift - {1'b0, dvs_mag};
   end

   // State register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and busy flag
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = divisor_zero ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == '0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, one quotient bit per CALC cycle, sign fix-up
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         quo         <= '0;
         dvs_mag     <= '0;
         rem         <= '0;
         cnt         <= '0;
         sq          <= 1'b0;
         sr          <= 1'b0;
         div_by_zero <= 1'b0;
         result      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor_zero) begin
                     result      <= {dividend, {WIDTH{1'b1}}};
                     div_by_zero <= 1'b1;
                  end else begin
                     quo         <= dvd_abs;
                     dvs_mag     <= dvs_abs;
                     rem         <= '0;
                     cnt         <= CNT_W'(WIDTH - 1);
                     sq          <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     sr          <= dividend[WIDTH-1];
                     div_by_zero <= 1'b0;
                  end
               end
            end
            CALC: begin
               if (!trial_diff[WIDTH]) begin
                  rem <= trial_diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= trial_shift[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            FIX: begin
               // Quotient truncates toward zero; remainder follows the dividend sign
               result <= {(sr ? -rem : rem), (sq ? -quo : quo)};
            end
            default: begin
            end
         endcase
      end
   end

   // done is registered from the DONE state, so it pulses the cycle after DONE
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         done <= 1'b0;
      end else begin
         done <= (state == DONE);
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic model
module tb_div_unit;

   logic        clock;
   logic        clear;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [63:0] result;

   int checks;
   int failures;

   div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .result      (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: truncating signed division in 64-bit arithmetic
   function automatic logic [63:0] model_result(input logic [31:0] a, input logic [31:0] b);
      longint na;
      longint nb;
      longint q;
      longint r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      na = longint'($signed(a));
      nb = longint'($signed(b));
      q  = na / nb;
      r  = na - q * nb;
      return {r[31:0], q[31:0]};
   endfunction

   // Launch one operation and observe it; lat = edge count to done, -1 if never seen
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt, output int dcnt);
      @(negedge clock);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      bcnt  = busy ? 1 : 0;
      lat   = -1;
      dcnt  = 0;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clock);
         #1;
         if (busy) bcnt++;
         if (done) begin
            dcnt++;
            if (lat < 0) lat = e;
         end
         if (lat >= 0 && e >= lat + 2) break;
      end
   endtask

   task automatic test_reset();
      clear    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
      end
      checks++;
      if (result !== 64'd0) begin
         failures++;
         $display("FAIL reset_result: got %h expected 0", result);
      end
      @(negedge clock);
      clear = 1'b1;
   endtask

   task automatic test_basic();
      int lat, bcnt, dcnt;
      run_op(32'd100, 32'd7, lat, bcnt, dcnt);
      checks++;
      if (lat !== 34) begin
         failures++;
         $display("FAIL basic_latency: got %0d expected 34", lat);
      end
      checks++;
      if (bcnt !== 33) begin
         failures++;
         $display("FAIL basic_busy_cycles: got %0d expected 33", bcnt);
      end
      checks++;
      if (dcnt !== 1) begin
         failures++;
         $display("FAIL basic_done_count: got %0d expected 1", dcnt);
      end
      checks++;
      if (result !== 64'h00000002_0000000E) begin
         failures++;
         $display("FAIL basic_result: got %h expected 000000020000000e", result);
      end
      checks++;
      if (div_by_zero !== 1'b0) begin
         failures++;
         $display("FAIL basic_dbz: got %b expected 0", div_by_zero);
      end
   endtask

   task automatic test_signed();
      logic [31:0] a_tab [3] = '{-32'sd100, 32'sd100, -32'sd100};
      logic [31:0] b_tab [3] = '{32'sd7, -32'sd7, -32'sd7};
      logic [63:0] r_tab [3] = '{64'hFFFFFFFE_FFFFFFF2, 64'h00000002_FFFFFFF2, 64'hFFFFFFFE_0000000E};
      int lat, bcnt, dcnt;
      for (int i = 0; i < 3; i++) begin
         run_op(a_tab[i], b_tab[i], lat, bcnt, dcnt);
         checks++;
         if (result !== r_tab[i] || lat !== 34) begin
            failures++;
            $display("FAIL signed_%0d: got %h lat %0d expected %h lat 34", i, result, lat, r_tab[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat, bcnt, dcnt;
      run_op(32'd7, 32'd0, lat, bcnt, dcnt);
      checks++;
      if (lat !== 1 || bcnt !== 0) begin
         failures++;
         $display("FAIL dbz_timing: got lat %0d busy %0d expected lat 1 busy 0", lat, bcnt);
      end
      checks++;
      if (div_by_zero !== 1'b1) begin
         failures++;
         $display("FAIL dbz_flag: got %b expected 1", div_by_zero);
      end
      checks++;
      if (result !== 64'h00000007_FFFFFFFF) begin
         failures++;
         $display("FAIL dbz_result: got %h expected 00000007ffffffff", result);
      end
      run_op(32'd9, 32'd3, lat, bcnt, dcnt);
      checks++;
      if (div_by_zero !== 1'b0 || result !== 64'h00000000_00000003) begin
         failures++;
         $display("FAIL dbz_clear: got dbz %b result %h expected dbz 0 result 0000000000000003",
                  div_by_zero, result);
      end
   endtask

   task automatic test_overflow();
      int lat, bcnt, dcnt;
      run_op(32'h80000000, 32'hFFFFFFFF, lat, bcnt, dcnt);
      checks++;
      if (result !== 64'h00000000_80000000 || div_by_zero !== 1'b0) begin
         failures++;
         $display("FAIL overflow: got %h dbz %b expected 0000000080000000 dbz 0", result, div_by_zero);
      end
      run_op(32'd5, 32'd9, lat, bcnt, dcnt);
      checks++;
      if (result !== 64'h00000005_00000000) begin
         failures++;
         $display("FAIL small_dividend: got %h expected 0000000500000000", result);
      end
   endtask

   task automatic test_ignore_restart();
      int lat, dcnt;
      @(negedge clock);
      dividend = 32'd1000;
      divisor  = 32'd10;
      start    = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat   = -1;
      dcnt  = 0;
      for (int e = 1; e <= 45; e++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         if (done) begin
            dcnt++;
            if (lat < 0) lat = e;
         end
         if (e == 5) begin
            dividend = 32'd77;
            divisor  = 32'd3;
            start    = 1'b1;
         end
      end
      checks++;
      if (lat !== 34 || dcnt !== 1) begin
         failures++;
         $display("FAIL restart_timing: got lat %0d dones %0d expected lat 34 dones 1", lat, dcnt);
      end
      checks++;
      if (result !== 64'h00000000_00000064) begin
         failures++;
         $display("FAIL restart_result: got %h expected 0000000000000064", result);
      end
   endtask

   task automatic test_async_reset();
      int lat, bcnt, dcnt;
      @(negedge clock);
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #3;
      clear = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000 || result !== 64'd0) begin
         failures++;
         $display("FAIL async_clear: got flags %b result %h expected 000 and 0",
                  {busy, done, div_by_zero}, result);
      end
      dcnt = 0;
      repeat (5) begin
         @(posedge clock);
         #1;
         if (done || busy) dcnt++;
      end
      checks++;
      if (dcnt !== 0) begin
         failures++;
         $display("FAIL async_hold: got %0d active cycles expected 0", dcnt);
      end
      @(negedge clock);
      clear = 1'b1;
      run_op(32'd50, 32'd5, lat, bcnt, dcnt);
      checks++;
      if (lat !== 34 || result !== 64'h00000000_0000000A) begin
         failures++;
         $display("FAIL after_reset: got lat %0d result %h expected lat 34 result 000000000000000a",
                  lat, result);
      end
   endtask

   task automatic test_random();
      int lat, bcnt, dcnt;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_r;
      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = {{24{b[31]}}, b[7:0]};
            default: begin end
         endcase
         exp_r = model_result(a, b);
         run_op(a, b, lat, bcnt, dcnt);
         checks++;
         if (result !== exp_r || div_by_zero !== (b == 32'd0) ||
             lat !== ((b == 32'd0) ? 1 : 34) || dcnt !== 1) begin
            failures++;
            $display("FAIL random_%0d %h/%h: got %h dbz %b lat %0d dones %0d expected %h dbz %b lat %0d",
                     i, a, b, result, div_by_zero, lat, dcnt, exp_r, (b == 32'd0),
                     (b == 32'd0) ? 1 : 34);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_ignore_restart();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
